fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised next-generation instruction fetch stage. Issues pipelined word reads to instruction memory through a request/grant/response handshake and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. Presents one instruction per cycle to decode and honours decode stall. Supports a branch/jump redirect that flushes queued and in-flight fetches.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h8002_0000, PC loaded on reset
DEPTH, 4, prefetch queue entries (power of two, >=2); also caps outstanding reads
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk_in  in  1  clock, all state on rising edge
rst_in  in  1  asynchronous, active-high reset
stall_in  in  1  decode cannot accept this cycle
redirect_in  in  1  one-cycle pulse: flush and restart fetch
redirect_pc_in  in  ADDR_W  target PC, valid with redirect_in
mem_req_out  out  1  read request valid
mem_addr_out  out  ADDR_W  request address
rw_out  out  1  1 = read; constant 1
access_size_out  out  2  constant ACCESS_WORD (2'b00)
mem_gnt_in  in  1  request accepted this cycle (mem_req_out && mem_gnt_in)
mem_rvalid_in  in  1  read data valid; responses return in request order
mem_rdata_in  in  DATA_W  read data
insn_valid_out  out  1  insn_out/insn_pc_out valid
insn_out  out  DATA_W  instruction at queue head
insn_pc_out  out  ADDR_W  PC of insn_out

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=S_INIT; mem_req_out=0, mem_addr_out=RESET_PC, insn_valid_out=0, insn_out=0, insn_pc_out=0. rw_out=1 and access_size_out=2'b00 at all times.
- FSM: S_INIT -> S_FETCH after one cycle (no request in S_INIT). S_FETCH -> S_DRAIN on redirect_in with outstanding-in-flight>0 (after that cycle's accounting); else stays S_FETCH. S_DRAIN -> S_FETCH when drop_cnt reaches 0.
- Request: in S_FETCH, mem_req_out=1 iff (queue_count + outstanding) < DEPTH and !redirect_in; mem_addr_out=fetch_pc. On grant: fetch_pc += PC_STEP (wraps mod 2^ADDR_W), outstanding++, and the address is pushed into an internal PC-tag FIFO. Request held stable until granted.
- Response: on mem_rvalid_in, outstanding--; if drop_cnt>0, discard and drop_cnt--; else push {pc_tag, mem_rdata_in} into the queue. A response with outstanding==0 is illegal (sim assertion).
- Output: insn_valid_out = !empty && !redirect_in. Pop when insn_valid_out && !stall_in. Push and pop in the same cycle are both allowed, including when full; count unchanged.
- Redirect (priority over everything): queue and PC-tag FIFO cleared; drop_cnt = outstanding after that cycle's response (a same-cycle response is discarded); fetch_pc = {redirect_pc_in[ADDR_W-1:2], 2'b00}; no grant is accepted that cycle. Redirect in S_DRAIN reloads fetch_pc and adds nothing to drop_cnt beyond the current outstanding.
- Stall: queue fills to DEPTH, then mem_req_out=0; no overflow is possible by construction.
- Latency: redirect to first request = 1 cycle if nothing in flight; 1-cycle memory gives a 2-cycle request-to-insn_valid_out.

Optional Feature:
FETCH_PERF_EN defined: adds outputs perf_fetched_out[31:0] (count of popped instructions) and perf_stall_out[31:0] (cycles with insn_valid_out && stall_in), both reset to 0 and wrapping. Undefined: ports and counters absent, no other change.

Decomposition:
- fetch_pkg: ACCESS_WORD=2'b00, RW_READ=1'b1, FSM state encodings (S_INIT, S_FETCH, S_DRAIN), default RESET_PC.
- Sub-module fetch_queue: synchronous FIFO (WIDTH, DEPTH; push/pop/flush, full/empty/count), instantiated for both the instruction queue and the PC-tag FIFO.

Test Plan:
- Reset then 1-cycle memory (gnt=1, rvalid next cycle), stall_in=0 -> insn_pc_out sequence 80020000, 80020004, 80020008... one per cycle from cycle 3.
- stall_in=1 for 10 cycles -> queue reaches 4, mem_req_out drops to 0, insn_pc_out held at 80020000; release -> 4 back-to-back pops with no PC gap.
- gnt held 0 for 3 cycles -> mem_addr_out stable at 80020000, no fetch_pc advance.
- 3-cycle latency memory with 2 reads outstanding, redirect_in with redirect_pc_in=80020103 -> both stale responses dropped, next request addr 80020100, first valid insn_pc_out=80020100.
- Redirect in the same cycle as rvalid and pop -> insn_valid_out=0 that cycle, response discarded, no stale PC delivered.
- fetch_pc=FFFFFFFC (via redirect), ADDR_W=32 -> next request address wraps to 00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [1:0]  ACCESS_WORD      = 2'b00;
    localparam logic        RW_READ          = 1'b1;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head entry is visible combinationally on o_head_dat.
// Latency: push visible at head one cycle later; pop takes effect at the clock edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // A pop frees the slot the same-cycle push needs, so push-while-full is legal with pop.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer, count and storage update; flush empties without touching storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch: pipelined word reads into a DEPTH-entry prefetch queue; optional perf counters under FETCH_PERF_EN.
// Latency: 2 cycles request-to-insn_valid_out with a 1-cycle memory; 1 cycle redirect-to-request when idle.
// Backpressure: stall_in holds the head; requests stop once queued + in-flight reaches DEPTH.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              rw_out,
    output logic [1:0]        access_size_out,
    input  logic              mem_gnt_in,
    input  logic              mem_rvalid_in,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic              insn_valid_out,
    output logic [DATA_W-1:0] insn_out,
    output logic [ADDR_W-1:0] insn_pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_out,
    output logic [31:0]       perf_stall_out
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  w_drop_nxt;
    logic [CNT_W-1:0]  w_out_after_rsp;
    logic [CNT_W:0]    w_inflight;
    logic [CNT_W-1:0]  w_q_count;
    logic [CNT_W-1:0]  w_tag_count;
    logic              w_q_empty;
    logic              w_q_full;
    logic              w_tag_empty;
    logic              w_tag_full;
    logic              w_gnt;
    logic              w_rsp_keep;
    logic              w_pop;
    logic [ENT_W-1:0]  w_q_head;
    logic [ADDR_W-1:0] w_tag_head;

    assign rw_out          = RW_READ;
    assign access_size_out = ACCESS_WORD;
    assign mem_addr_out    = r_fetch_pc;

    // Requests are blocked during redirect, so a grant never coincides with a flush.
    assign w_gnt           = mem_req_out && mem_gnt_in;
    assign w_out_after_rsp = r_outstanding - {{(CNT_W-1){1'b0}}, mem_rvalid_in};
    assign w_inflight      = {1'b0, w_q_count} + {1'b0, r_outstanding};
    // Responses belonging to flushed requests (drop_cnt) or arriving with a redirect are discarded.
    assign w_rsp_keep      = mem_rvalid_in && (r_drop_cnt == '0) && !redirect_in;
    assign insn_valid_out  = !w_q_empty && !redirect_in;
    assign w_pop           = insn_valid_out && !stall_in;
    assign {insn_pc_out, insn_out} = w_q_head;

    // Stale-response counter: reloaded from the in-flight count on redirect, decremented per drop.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_in) begin
            w_drop_nxt = w_out_after_rsp;
        end else if (mem_rvalid_in && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - CNT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: drain only while flushed requests are still returning.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  w_state_nxt = S_FETCH;
            S_FETCH: if (redirect_in && (w_out_after_rsp != '0)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drop_nxt == '0) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // FSM output: request while queue plus in-flight reads leave room for another entry.
    always_comb begin
        mem_req_out = 1'b0;
        if ((r_state == S_FETCH) && !redirect_in && (w_inflight < (CNT_W+1)'(DEPTH))) begin
            mem_req_out = 1'b1;
        end
    end

    // Fetch PC, outstanding-read and drop bookkeeping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_after_rsp + {{(CNT_W-1){1'b0}}, w_gnt};
            r_drop_cnt    <= w_drop_nxt;
            if (redirect_in) begin
                r_fetch_pc <= redirect_pc_in & ~ADDR_W'(3);
            end else if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    // PC of every granted request, consumed in order by kept responses.
    fetch_queue #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_push     (w_gnt),
        .i_push_dat (r_fetch_pc),
        .i_pop      (w_rsp_keep),
        .i_flush    (redirect_in),
        .o_full     (w_tag_full),
        .o_empty    (w_tag_empty),
        .o_count    (w_tag_count),
        .o_head_dat (w_tag_head)
    );

    // Prefetch queue of {pc, instruction} pairs presented to decode.
    fetch_queue #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_insn_queue (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_push     (w_rsp_keep),
        .i_push_dat ({w_tag_head, mem_rdata_in}),
        .i_pop      (w_pop),
        .i_flush    (redirect_in),
        .o_full     (w_q_full),
        .o_empty    (w_q_empty),
        .o_count    (w_q_count),
        .o_head_dat (w_q_head)
    );

`ifdef FETCH_PERF_EN
    // Popped-instruction and decode-stall cycle counters, free-running with wrap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_fetched_out <= '0;
            perf_stall_out   <= '0;
        end else begin
            if (w_pop) perf_fetched_out <= perf_fetched_out + 32'd1;
            if (insn_valid_out && stall_in) perf_stall_out <= perf_stall_out + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

    // A response can only answer an issued request.
    a_rsp_has_req: assert property (@(posedge clk_in) disable iff (rst_in)
        mem_rvalid_in |-> (r_outstanding != '0));
    // Every live read owns exactly one PC tag outside of drain.
    a_tag_tracks: assert property (@(posedge clk_in) disable iff (rst_in)
        (r_state == S_FETCH) |-> (w_tag_count == r_outstanding));
    a_tag_room: assert property (@(posedge clk_in) disable iff (rst_in)
        w_gnt |-> !w_tag_full);
    a_tag_avail: assert property (@(posedge clk_in) disable iff (rst_in)
        w_rsp_keep |-> !w_tag_empty);
    a_queue_room: assert property (@(posedge clk_in) disable iff (rst_in)
        w_rsp_keep |-> (!w_q_full || w_pop));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a behavioural in-order memory of configurable latency.
// Latency: inputs change on the falling edge; outputs sampled 2 time units after it.
// Backpressure: memory grant is steered per test through gnt_en.
module tb_fetch_prefetch;

    localparam logic [31:0] RPC = 32'h8002_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        rw_out;
    logic [1:0]  access_size_out;
    logic        mem_gnt_in = 1'b0;
    logic        mem_rvalid_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        insn_valid_out;
    logic [31:0] insn_out;
    logic [31:0] insn_pc_out;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_out;
    logic [31:0] perf_stall_out;
`endif

    int total = 0;
    int bad = 0;

    // memory model controls and pending-read list
    bit          gnt_en = 1'b1;
    int          lat = 1;
    int          ncyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    fetch_prefetch dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .rw_out          (rw_out),
        .access_size_out (access_size_out),
        .mem_gnt_in      (mem_gnt_in),
        .mem_rvalid_in   (mem_rvalid_in),
        .mem_rdata_in    (mem_rdata_in),
        .insn_valid_out  (insn_valid_out),
        .insn_out        (insn_out),
        .insn_pc_out     (insn_pc_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_out(perf_fetched_out),
        .perf_stall_out  (perf_stall_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: answer in order lat cycles after each grant, one response per cycle.
    always begin
        @(negedge clk_in);
        #1;
        if (rst_in) begin
            pend_addr.delete();
            pend_due.delete();
            mem_gnt_in    = 1'b0;
            mem_rvalid_in = 1'b0;
        end else begin
            mem_gnt_in = gnt_en;
            if (pend_due.size() > 0 && pend_due[0] <= ncyc) begin
                mem_rvalid_in = 1'b1;
                mem_rdata_in  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid_in = 1'b0;
            end
            if (mem_req_out && mem_gnt_in) begin
                pend_addr.push_back(mem_addr_out);
                pend_due.push_back(ncyc + lat);
            end
        end
        ncyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Returns at the falling edge where reset is released.
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        stall_in = 1'b0;
        redirect_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Advance to next sample point until insn_valid_out or budget exhausted.
    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            #2;
            if (insn_valid_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        #2;
        total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req_out); end
        total++; if (mem_addr_out !== RPC) begin bad++; $display("FAIL rst_addr got=%h want=%h", mem_addr_out, RPC); end
        total++; if (insn_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", insn_valid_out); end
        total++; if (insn_out !== 32'h0) begin bad++; $display("FAIL rst_insn got=%h want=0", insn_out); end
        total++; if (insn_pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", insn_pc_out); end
        total++; if (rw_out !== 1'b1) begin bad++; $display("FAIL rst_rw got=%b want=1", rw_out); end
        total++; if (access_size_out !== 2'b00) begin bad++; $display("FAIL rst_size got=%b want=00", access_size_out); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        gnt_en = 1'b1; lat = 1;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            #2;
            if (k == 1) begin
                total++; if (mem_req_out !== 1'b1 || mem_addr_out !== RPC) begin
                    bad++; $display("FAIL stream_first_req got=%b/%h want=1/%h", mem_req_out, mem_addr_out, RPC); end
            end
            if (k < 3) begin
                total++; if (insn_valid_out !== 1'b0) begin bad++; $display("FAIL stream_early_valid k=%0d got=%b want=0", k, insn_valid_out); end
            end else begin
                epc = RPC + 32'(4 * (k - 3));
                total++; if (insn_valid_out !== 1'b1 || insn_pc_out !== epc) begin
                    bad++; $display("FAIL stream_pc k=%0d got=%b/%h want=1/%h", k, insn_valid_out, insn_pc_out, epc); end
                total++; if (insn_out !== mem_word(epc)) begin
                    bad++; $display("FAIL stream_insn k=%0d got=%h want=%h", k, insn_out, mem_word(epc)); end
                total++; if (rw_out !== 1'b1 || access_size_out !== 2'b00) begin
                    bad++; $display("FAIL stream_attr got=%b/%b want=1/00", rw_out, access_size_out); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] epc;
        gnt_en = 1'b1; lat = 1;
        do_reset();
        stall_in = 1'b1;
        repeat (10) begin @(negedge clk_in); #2; end
        total++; if (mem_req_out !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", mem_req_out); end
        total++; if (insn_valid_out !== 1'b1 || insn_pc_out !== RPC) begin
            bad++; $display("FAIL stall_hold got=%b/%h want=1/%h", insn_valid_out, insn_pc_out, RPC); end
        @(negedge clk_in);
        stall_in = 1'b0;
        #2;
        for (int j = 0; j < 6; j++) begin
            epc = RPC + 32'(4 * j);
            total++; if (insn_valid_out !== 1'b1 || insn_pc_out !== epc) begin
                bad++; $display("FAIL stall_release j=%0d got=%b/%h want=1/%h", j, insn_valid_out, insn_pc_out, epc); end
            @(negedge clk_in);
            #2;
        end
    endtask

    task automatic test_gnt_hold();
        bit ok;
        gnt_en = 1'b0; lat = 1;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            #2;
            total++; if (mem_req_out !== 1'b1 || mem_addr_out !== RPC) begin
                bad++; $display("FAIL gnt_hold k=%0d got=%b/%h want=1/%h", k, mem_req_out, mem_addr_out, RPC); end
        end
        @(negedge clk_in);
        gnt_en = 1'b1;
        #2;
        total++; if (mem_addr_out !== RPC) begin bad++; $display("FAIL gnt_hold_last got=%h want=%h", mem_addr_out, RPC); end
        @(negedge clk_in);
        #2;
        total++; if (mem_addr_out !== RPC + 32'd4) begin bad++; $display("FAIL gnt_advance got=%h want=%h", mem_addr_out, RPC + 32'd4); end
        wait_valid(10, ok);
        total++; if (!ok || insn_pc_out !== RPC) begin
            bad++; $display("FAIL gnt_first_insn got=%b/%h want=1/%h", ok, insn_pc_out, RPC); end
    endtask

    task automatic test_redirect_drain();
        bit ok;
        int n;
        gnt_en = 1'b1; lat = 3;
        do_reset();
        repeat (2) begin @(negedge clk_in); #2; end
        @(negedge clk_in);
        redirect_in = 1'b1;
        redirect_pc_in = 32'h8002_0103;
        #2;
        total++; if (mem_req_out !== 1'b0 || insn_valid_out !== 1'b0) begin
            bad++; $display("FAIL drain_redir_cycle got=%b/%b want=0/0", mem_req_out, insn_valid_out); end
        @(negedge clk_in);
        redirect_in = 1'b0;
        #2;
        n = 0;
        while (!mem_req_out && n < 20) begin
            total++; if (insn_valid_out !== 1'b0) begin bad++; $display("FAIL drain_stale got=%h want=none", insn_pc_out); end
            @(negedge clk_in);
            #2;
            n++;
        end
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h8002_0100) begin
            bad++; $display("FAIL drain_new_req got=%b/%h want=1/80020100", mem_req_out, mem_addr_out); end
        wait_valid(12, ok);
        total++; if (!ok || insn_pc_out !== 32'h8002_0100 || insn_out !== mem_word(32'h8002_0100)) begin
            bad++; $display("FAIL drain_first_insn got=%b/%h/%h want=1/80020100/%h", ok, insn_pc_out, insn_out, mem_word(32'h8002_0100)); end
    endtask

    task automatic test_redirect_same_cycle();
        bit ok;
        gnt_en = 1'b1; lat = 1;
        do_reset();
        repeat (6) begin @(negedge clk_in); #2; end
        total++; if (insn_valid_out !== 1'b1) begin bad++; $display("FAIL same_pre_valid got=%b want=1", insn_valid_out); end
        @(negedge clk_in);
        redirect_in = 1'b1;
        redirect_pc_in = 32'h8002_0200;
        #2;
        total++; if (insn_valid_out !== 1'b0 || mem_req_out !== 1'b0) begin
            bad++; $display("FAIL same_redir_cycle got=%b/%b want=0/0", insn_valid_out, mem_req_out); end
        @(negedge clk_in);
        redirect_in = 1'b0;
        #2;
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h8002_0200 || insn_valid_out !== 1'b0) begin
            bad++; $display("FAIL same_next_req got=%b/%h/%b want=1/80020200/0", mem_req_out, mem_addr_out, insn_valid_out); end
        wait_valid(10, ok);
        total++; if (!ok || insn_pc_out !== 32'h8002_0200) begin
            bad++; $display("FAIL same_first_insn got=%b/%h want=1/80020200", ok, insn_pc_out); end
    endtask

    task automatic test_wrap();
        gnt_en = 1'b1; lat = 1;
        do_reset();
        @(negedge clk_in);
        redirect_in = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFE;
        #2;
        @(negedge clk_in);
        redirect_in = 1'b0;
        #2;
        total++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req got=%b/%h want=1/fffffffc", mem_req_out, mem_addr_out); end
        @(negedge clk_in);
        #2;
        total++; if (mem_addr_out !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", mem_addr_out); end
        @(negedge clk_in);
        #2;
        total++; if (insn_valid_out !== 1'b1 || insn_pc_out !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_insn0 got=%b/%h want=1/fffffffc", insn_valid_out, insn_pc_out); end
        @(negedge clk_in);
        #2;
        total++; if (insn_valid_out !== 1'b1 || insn_pc_out !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_insn1 got=%b/%h want=1/00000000", insn_valid_out, insn_pc_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_hold();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
